sync_fifo_buffer: RTL
=====================

# sync_fifo_buffer

Single-clock, parametrised FIFO buffer: the next generation of our FIFO storage block, replacing the combinational array with a registered, pointer-managed queue. It owns its read/write pointers and occupancy count, and reports full, empty and programmable almost-full/almost-empty status. It also flags overflow and underflow, and supports a synchronous flush. It sits between a producer and consumer in the same clock domain, and is the storage core for the datapath buffers.

## Interface

- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 7, pointer width; depth DEPTH = 2**ADDR_WIDTH (default 128)
- AF_LEVEL, DEPTH-4, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  one clock; reset is synchronous and active-high
- flush  input  1  synchronous clear of queue state (active-high)
- write_enable  input  1  write request
- data_in  input  DATA_WIDTH  write data
- read_enable  input  1  read request
- data_out  output  DATA_WIDTH  registered read data
- data_valid  output  1  data_out updated this cycle by an accepted read
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write requested while full and not accepted
- underflow  output  1  one-cycle pulse: read requested while empty

## Operation

- Priority per edge: reset > flush > normal operation.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0. Derived flags follow: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
- Flush: same register values as reset. Read and write requests in the flush cycle are ignored, and no overflow or underflow pulse is generated. Memory array is not cleared; it is never reset.
- Write accepted (wr_acc) = write_enable && (!full || read_enable). On accept: mem[wr_ptr] <= data_in, wr_ptr increments.
- Read accepted (rd_acc) = read_enable && !empty. On accept: data_out <= mem[rd_ptr], rd_ptr increments.
- No fall-through: on empty, simultaneous read+write accepts the write only and pulses underflow.
- On full, simultaneous read+write accepts both. The read returns the oldest word, the write lands in the freed slot, and count is unchanged.
- count: +1 when wr_acc only, -1 when rd_acc only, unchanged when both or neither.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH (DEPTH-1 -> 0) with no special handling.
- overflow <= write_enable && full && !read_enable. underflow <= read_enable && empty. Both are cleared the next cycle unless re-triggered.
- data_out holds its last value when no read is accepted.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count. They carry no extra latency.

## Timing

- Write-to-visible: a word written at edge N raises count/clears empty after edge N. It is readable with read_enable in cycle N+1.
- Read latency 1: with read_enable high and empty low in cycle N, data_out and data_valid=1 appear after edge N. data_valid drops the following cycle if no further read is accepted.
- Back-to-back reads sustain one word per cycle. data_valid stays high throughout.
- Reset or flush asserted mid-stream takes effect at that edge. Any read in that cycle produces no data_valid.
- The status decode settles within the same cycle as count. The producer must sample full before asserting write_enable.

## Test plan

Bench uses ADDR_WIDTH=3 (DEPTH=8), AF_LEVEL=6, AE_LEVEL=1, DATA_WIDTH=32.

- Reset, then idle 2 cycles. Required: count=0, empty=1, almost_empty=1, full=0, data_out=0, data_valid=0.
- Write 0x11..0x88 (8 writes), then 1 extra write of 0x99. Required: almost_full at count=6, full at count=8, overflow pulses exactly 1 cycle, 0x99 dropped. Then 8 reads return 0x11..0x88 in order with data_valid each cycle, and empty=1 at the end.
- Read while empty, and read+write (0xA5) while empty. Required: underflow pulses each time, no data_valid, count ends 1. The next read returns 0xA5.
- Fill to full, then hold read+write with 0xB0..0xBF for 16 cycles. Required: count stays 8, full stays 1, no overflow. Reads return the original 8 then 0xB0..0xB7, exercising pointer wrap twice.
- At count=5, assert flush together with a write of 0xCC. Required: count=0, empty=1, data_out=0, no overflow. The next read pulses underflow.
- Assert reset during back-to-back reads at count=4. Required: data_valid=0 and data_out=0 after that edge, and count=0.

Source files
------------

// File: rtl/sync_fifo_buffer_if.sv
// Handshake and status bundle between a producer/consumer pair and the FIFO.
// master: the client side (drives requests and write data, observes status).
// slave : the FIFO side (accepts requests, returns read data and status).
// Ports carried: flush, write_enable, data_in, read_enable, data_out,
// data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow.
interface sync_fifo_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 7
);
    logic                  flush;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, write_enable, data_in, read_enable,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, write_enable, data_in, read_enable,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_buffer.sv
// Single-clock pointer-managed FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty, overflow/underflow pulses and flush.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   fifo  - sync_fifo_buffer_if.slave (requests in, data/status out)
// full/empty/almost_* are decodes of the registered count; all else registered.
module sync_fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic              clk,
    input  logic              reset,
    sync_fifo_buffer_if.slave fifo
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full_c;
    logic empty_c;
    logic wr_acc_c;
    logic rd_acc_c;

    // Status decode straight off the count register.
    assign full_c   = (count_q == CNT_W'(DEPTH));
    assign empty_c  = (count_q == '0);

    // A write on full is still taken when a read frees a slot the same edge.
    assign wr_acc_c = fifo.write_enable && (!full_c || fifo.read_enable);
    assign rd_acc_c = fifo.read_enable && !empty_c;

    // Storage array; never reset, writes suppressed during reset/flush.
    always_ff @(posedge clk) begin
        if (!reset && !fifo.flush && wr_acc_c) begin
            mem[wr_ptr_q] <= fifo.data_in;
        end
    end

    // Pointers, count, read data and event pulses.
    always_ff @(posedge clk) begin
        if (reset || fifo.flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_acc_c) begin
                rd_ptr_q   <= rd_ptr_q + ADDR_WIDTH'(1);
                data_out_q <= mem[rd_ptr_q];
            end
            data_valid_q <= rd_acc_c;
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= fifo.write_enable && full_c && !fifo.read_enable;
            underflow_q <= fifo.read_enable && empty_c;
        end
    end

    assign fifo.data_out     = data_out_q;
    assign fifo.data_valid   = data_valid_q;
    assign fifo.count        = count_q;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
    assign fifo.full         = full_c;
    assign fifo.empty        = empty_c;
    assign fifo.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign fifo.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
endmodule
